// File: rtl/fetch_pkg.sv
// Shared types and constants for the 9-bit ISA fetch front end: FSM state
// encoding, the halt/NOP encodings and default widths.
package fetch_pkg;

  localparam int PW_DEF = 10;
  localparam int IW_DEF = 9;
  localparam int LW_DEF = 4;

  localparam logic [8:0] HALT_CODE = 9'h1FF;
  localparam logic [8:0] NOP_CODE  = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup table: 2**LW absolute PCs, written while the fetch
// unit is idle and read combinationally by the branch index of the live instruction.
module branch_lut #(
  parameter int PW = fetch_pkg::PW_DEF,
  parameter int LW = fetch_pkg::LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [LW-1:0] waddr_i,
  input  logic [PW-1:0] wdata_i,
  input  logic [LW-1:0] raddr_i,
  output logic [PW-1:0] rdata_o
);

  logic [PW-1:0] lut_q [2**LW];

  // NOTE: this array is small and its reset-to-zero contents are visible
  // behaviour, so it is built from flops with an async clear, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**LW; i++) lut_q[i] <= '0;
    end else if (we_i) begin
      lut_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = lut_q[raddr_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing front end: PC, branch squash, stall hold and
// halt/end-of-ROM detection. Define FETCH_TRACE_EN to add the instr_count port.
module fetch_unit #(
  parameter int            PW        = fetch_pkg::PW_DEF,
  parameter int            IW        = fetch_pkg::IW_DEF,
  parameter int            LW        = fetch_pkg::LW_DEF,
  parameter logic [IW-1:0] HALT_CODE = IW'(fetch_pkg::HALT_CODE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [LW-1:0] branch_idx,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [PW-1:0] lut_wdata,
  input  logic [IW-1:0] rom_data,
  output logic [PW-1:0] prog_ctr,
  output logic [IW-1:0] mach_code,
  output logic          instr_valid,
  output logic          done
`ifdef FETCH_TRACE_EN
  ,
  output logic [15:0]   instr_count
`endif
);

  import fetch_pkg::*;

  localparam logic [PW-1:0] PC_LAST = '1;
  localparam logic [IW-1:0] NOP     = IW'(NOP_CODE);

  state_e        state_q;
  logic [PW-1:0] pc_q;
  logic [PW-1:0] lut_target;
  logic [IW-1:0] mach_q;
  logic          valid_q;
  logic          done_q;
  logic          end_q;
  logic          lut_wr_en;
  logic          branch_go;
  logic          restart;

  assign lut_wr_en = (state_q == IDLE) && lut_we && !stall;
  assign branch_go = valid_q && branch_taken;
  assign restart   = start && (state_q != RUN);

  branch_lut #(
    .PW (PW),
    .LW (LW)
  ) u_lut (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (lut_wr_en),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata),
    .raddr_i (branch_idx),
    .rdata_o (lut_target)
  );

  // NOTE: all state updates use <= so every branch of the FSM sees the
  // pre-edge values of pc_q/valid_q regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      mach_q  <= NOP;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, HALT: begin
          if (restart) begin
            state_q <= RUN;
            pc_q    <= '0;
            mach_q  <= NOP;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            end_q   <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (branch_go) begin
              pc_q    <= lut_target;
              mach_q  <= NOP;
              valid_q <= 1'b0;
              end_q   <= 1'b0;
            end else if (end_q || rom_data == HALT_CODE) begin
              // end_q: the last ROM word was already issued; pc stays put.
              state_q <= HALT;
              mach_q  <= NOP;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              end_q   <= 1'b0;
            end else begin
              mach_q  <= rom_data;
              valid_q <= 1'b1;
              if (pc_q == PC_LAST) end_q <= 1'b1;
              else                 pc_q  <= pc_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prog_ctr    = pc_q;
  assign mach_code   = mach_q;
  assign instr_valid = valid_q;
  assign done        = done_q;

`ifdef FETCH_TRACE_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (restart) begin
      count_q <= '0;
    end else if (valid_q && !stall && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign instr_count = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && valid_q && !stall) begin
      $display("fetch_trace pc=%0h mach_code=%0h", pc_q, mach_q);
    end
  end
`endif
`endif

endmodule
